// File: rtl/rob_multi_commit_if.sv
// Bundle between the reorder buffer and its neighbours: rename allocation,
// CDB writeback, operand lookup, and the commit and redirect outputs.
interface rob_multi_commit_if #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int INFO_W  = 8
);
  localparam int TAG_W = $clog2(DEPTH);

  logic                      freeze;
  logic                      alloc_valid;
  logic [4:0]                alloc_dest;
  logic [INFO_W-1:0]         alloc_info;
  logic                      alloc_ready;
  logic [TAG_W-1:0]          alloc_tag;

  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_result;
  logic [NUM_CDB-1:0]        cdb_mispredict;
  logic [NUM_CDB*DATA_W-1:0] cdb_target;

  logic [TAG_W-1:0]          rd_tag_a;
  logic [TAG_W-1:0]          rd_tag_b;
  logic [DATA_W-1:0]         rd_value_a;
  logic [DATA_W-1:0]         rd_value_b;
  logic                      rd_ready_a;
  logic                      rd_ready_b;

  logic [1:0]                commit_valid;
  logic [2*TAG_W-1:0]        commit_tag;
  logic [2*5-1:0]            commit_dest;
  logic [2*DATA_W-1:0]       commit_result;
  logic [2*INFO_W-1:0]       commit_info;
  logic                      redirect_valid;
  logic [DATA_W-1:0]         redirect_target;
  logic [TAG_W:0]            count;
  logic                      empty;

  // Upstream side: rename, execution units and fetch.
  modport master (
    output freeze, alloc_valid, alloc_dest, alloc_info,
    output cdb_valid, cdb_tag, cdb_result, cdb_mispredict, cdb_target,
    output rd_tag_a, rd_tag_b,
    input  alloc_ready, alloc_tag,
    input  rd_value_a, rd_value_b, rd_ready_a, rd_ready_b,
    input  commit_valid, commit_tag, commit_dest, commit_result, commit_info,
    input  redirect_valid, redirect_target, count, empty
  );

  // Reorder buffer side.
  modport slave (
    input  freeze, alloc_valid, alloc_dest, alloc_info,
    input  cdb_valid, cdb_tag, cdb_result, cdb_mispredict, cdb_target,
    input  rd_tag_a, rd_tag_b,
    output alloc_ready, alloc_tag,
    output rd_value_a, rd_value_b, rd_ready_a, rd_ready_b,
    output commit_valid, commit_tag, commit_dest, commit_result, commit_info,
    output redirect_valid, redirect_target, count, empty
  );
endinterface

// File: rtl/rob_multi_commit.sv
// Reorder buffer: circular FIFO of DEPTH entries, NUM_CDB writeback ports,
// up to two in-order retirements per cycle, flush plus fetch redirect on a
// committing mispredict. Pointers carry one extra wrap bit so full and empty
// are distinguishable.
module rob_multi_commit #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int INFO_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  rob_multi_commit_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int PTR_W = TAG_W + 1;

  logic [4:0]        destMem   [DEPTH];
  logic [INFO_W-1:0] infoMem   [DEPTH];
  logic [DATA_W-1:0] resultMem [DEPTH];
  logic [DATA_W-1:0] targetMem [DEPTH];
  logic [DEPTH-1:0]  readyBits;
  logic [DEPTH-1:0]  mispBits;

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   count;
  logic [PTR_W-1:0]   headNext;
  logic [TAG_W-1:0]   headIdx;
  logic [TAG_W-1:0]   head1Idx;
  logic [TAG_W-1:0]   tailIdx;
  logic               full;
  logic               allocFire;
  logic               commit0;
  logic               commit1;
  logic               flush;
  logic [NUM_CDB-1:0] cdbHit;

  assign count    = tail - head;
  assign full     = (count == PTR_W'(DEPTH));
  assign headIdx  = head[TAG_W-1:0];
  assign head1Idx = headIdx + TAG_W'(1);
  assign tailIdx  = tail[TAG_W-1:0];

  assign bus.alloc_ready = !full;
  assign bus.alloc_tag   = tailIdx;
  assign bus.count       = count;
  assign bus.empty       = (count == '0);

  // Flush wins over allocation: the new entry would land past the redirect.
  assign allocFire = bus.alloc_valid && !full && !bus.freeze && !flush;

  // Retirement decision from the array contents before the edge.
  always_comb begin
    commit0  = (count != '0) && readyBits[headIdx];
    commit1  = commit0 && (count >= PTR_W'(2)) && readyBits[head1Idx] && !mispBits[headIdx];
    flush    = commit1 ? mispBits[head1Idx] : (commit0 && mispBits[headIdx]);
    headNext = head + PTR_W'(commit0) + PTR_W'(commit1);
  end

  // A CDB write only counts when its tag is live, i.e. its distance from head is below count.
  always_comb begin
    cdbHit = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      cdbHit[p] = bus.cdb_valid[p] &&
                  ({1'b0, TAG_W'(bus.cdb_tag[p*TAG_W +: TAG_W] - headIdx)} < count);
    end
  end

  // Operand port A: entry contents, overridden by a same-cycle broadcast (highest port wins).
  always_comb begin
    bus.rd_value_a = resultMem[bus.rd_tag_a];
    bus.rd_ready_a = readyBits[bus.rd_tag_a];
    for (int p = 0; p < NUM_CDB; p++) begin
      if (bus.cdb_valid[p] && (bus.cdb_tag[p*TAG_W +: TAG_W] == bus.rd_tag_a)) begin
        bus.rd_value_a = bus.cdb_result[p*DATA_W +: DATA_W];
        bus.rd_ready_a = 1'b1;
      end
    end
  end

  // Operand port B: same lookup as port A.
  always_comb begin
    bus.rd_value_b = resultMem[bus.rd_tag_b];
    bus.rd_ready_b = readyBits[bus.rd_tag_b];
    for (int p = 0; p < NUM_CDB; p++) begin
      if (bus.cdb_valid[p] && (bus.cdb_tag[p*TAG_W +: TAG_W] == bus.rd_tag_b)) begin
        bus.rd_value_b = bus.cdb_result[p*DATA_W +: DATA_W];
        bus.rd_ready_b = 1'b1;
      end
    end
  end

  // Payload storage; stale contents are harmless because ready bits gate every use.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_CDB; p++) begin
      if (cdbHit[p]) begin
        resultMem[bus.cdb_tag[p*TAG_W +: TAG_W]] <= bus.cdb_result[p*DATA_W +: DATA_W];
        targetMem[bus.cdb_tag[p*TAG_W +: TAG_W]] <= bus.cdb_target[p*DATA_W +: DATA_W];
      end
    end
    if (allocFire) begin
      destMem[tailIdx] <= bus.alloc_dest;
      infoMem[tailIdx] <= bus.alloc_info;
    end
  end

  // Pointers and per-entry status; later statements take priority (flush last).
  always_ff @(posedge clk) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      readyBits <= '0;
      mispBits  <= '0;
    end else begin
      for (int p = 0; p < NUM_CDB; p++) begin
        if (cdbHit[p]) begin
          readyBits[bus.cdb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
          mispBits[bus.cdb_tag[p*TAG_W +: TAG_W]]  <= bus.cdb_mispredict[p];
        end
      end
      if (allocFire) begin
        readyBits[tailIdx] <= 1'b0;
        mispBits[tailIdx]  <= 1'b0;
        tail               <= tail + PTR_W'(1);
      end
      if (flush) begin
        readyBits <= '0;
        tail      <= headNext;
      end
      head <= headNext;
    end
  end

  // Registered commit slots; payload fields hold when their slot is idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.commit_valid  <= '0;
      bus.commit_tag    <= '0;
      bus.commit_dest   <= '0;
      bus.commit_result <= '0;
      bus.commit_info   <= '0;
    end else begin
      bus.commit_valid <= {commit1, commit0};
      if (commit0) begin
        bus.commit_tag[0 +: TAG_W]     <= headIdx;
        bus.commit_dest[0 +: 5]        <= destMem[headIdx];
        bus.commit_result[0 +: DATA_W] <= resultMem[headIdx];
        bus.commit_info[0 +: INFO_W]   <= infoMem[headIdx];
      end
      if (commit1) begin
        bus.commit_tag[TAG_W +: TAG_W]      <= head1Idx;
        bus.commit_dest[5 +: 5]             <= destMem[head1Idx];
        bus.commit_result[DATA_W +: DATA_W] <= resultMem[head1Idx];
        bus.commit_info[INFO_W +: INFO_W]   <= infoMem[head1Idx];
      end
    end
  end

  // One-cycle redirect pulse carrying the youngest committing entry's target.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.redirect_valid  <= 1'b0;
      bus.redirect_target <= '0;
    end else begin
      bus.redirect_valid <= flush;
      if (flush) begin
        bus.redirect_target <= commit1 ? targetMem[head1Idx] : targetMem[headIdx];
      end
    end
  end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: directed scenarios followed by random traffic,
// all checked against a queue-of-entries model of the buffer.
module tb_rob_multi_commit;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int NUM_CDB = 2;
  localparam int INFO_W  = 8;
  localparam int TAG_W   = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rob_multi_commit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .INFO_W(INFO_W)) bus ();
  rob_multi_commit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .INFO_W(INFO_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int                tag;
    logic [4:0]        dest;
    logic [INFO_W-1:0] info;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] target;
    bit                ready;
    bit                misp;
  } ent_t;

  ent_t q[$];
  int   tailTag;
  int   vectors = 0;
  int   miscompares = 0;

  logic [1:0]        expCv;
  logic [TAG_W-1:0]  expTag  [2];
  logic [4:0]        expDest [2];
  logic [DATA_W-1:0] expRes  [2];
  logic [INFO_W-1:0] expInfo [2];
  logic              expRv;
  logic [DATA_W-1:0] expRt;

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tg, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    tailTag = 0;
    expCv = '0;
    expRv = 1'b0;
    expRt = '0;
    for (int s = 0; s < 2; s++) begin
      expTag[s] = '0; expDest[s] = '0; expRes[s] = '0; expInfo[s] = '0;
    end
  endtask

  task automatic setIdle();
    bus.freeze = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_dest = '0;
    bus.alloc_info = '0;
    bus.cdb_valid = '0;
    bus.cdb_tag = '0;
    bus.cdb_result = '0;
    bus.cdb_mispredict = '0;
    bus.cdb_target = '0;
    bus.rd_tag_a = '0;
    bus.rd_tag_b = '0;
  endtask

  task automatic setCdb(input int p, input int tag, input logic [DATA_W-1:0] res,
                        input logic misp, input logic [DATA_W-1:0] tgt);
    bus.cdb_valid[p] = 1'b1;
    bus.cdb_tag[p*TAG_W +: TAG_W] = TAG_W'(tag);
    bus.cdb_result[p*DATA_W +: DATA_W] = res;
    bus.cdb_mispredict[p] = misp;
    bus.cdb_target[p*DATA_W +: DATA_W] = tgt;
  endtask

  task automatic chkRd(input string nm, input logic [TAG_W-1:0] t,
                       input logic [DATA_W-1:0] v, input logic r);
    int hit;
    hit = -1;
    for (int p = 0; p < NUM_CDB; p++)
      if (bus.cdb_valid[p] && bus.cdb_tag[p*TAG_W +: TAG_W] == t) hit = p;
    if (hit >= 0) begin
      chk({nm, "_byp_val"}, 64'(v), 64'(bus.cdb_result[hit*DATA_W +: DATA_W]));
      chk({nm, "_byp_rdy"}, 64'(r), 64'd1);
    end else begin
      foreach (q[i]) if (q[i].tag == int'(t)) begin
        chk({nm, "_rdy"}, 64'(r), 64'(q[i].ready));
        if (q[i].ready) chk({nm, "_val"}, 64'(v), 64'(q[i].result));
      end
    end
  endtask

  // One clock: check combinational outputs, advance the model, clock, check registered outputs.
  task automatic step();
    int   n, sz, lastTag;
    bit   fl;
    ent_t e;
    #1;
    sz = q.size();
    chk("count", 64'(bus.count), 64'(sz));
    chk("empty", 64'(bus.empty), 64'(sz == 0));
    chk("alloc_ready", 64'(bus.alloc_ready), 64'(sz < DEPTH));
    chk("alloc_tag", 64'(bus.alloc_tag), 64'(tailTag));
    chkRd("rd_a", bus.rd_tag_a, bus.rd_value_a, bus.rd_ready_a);
    chkRd("rd_b", bus.rd_tag_b, bus.rd_value_b, bus.rd_ready_b);

    n = 0; fl = 1'b0; lastTag = 0;
    if (sz > 0 && q[0].ready) n = 1;
    if (n == 1 && sz >= 2 && q[1].ready && !q[0].misp) n = 2;
    if (n > 0) begin fl = q[n-1].misp; lastTag = q[n-1].tag; end

    if (!reset) begin
      modelReset();
    end else begin
      expCv = (n == 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
      for (int s = 0; s < n; s++) begin
        expTag[s] = TAG_W'(q[s].tag); expDest[s] = q[s].dest;
        expRes[s] = q[s].result;      expInfo[s] = q[s].info;
      end
      expRv = fl;
      if (fl) expRt = q[n-1].target;
      for (int p = 0; p < NUM_CDB; p++) begin
        if (bus.cdb_valid[p]) begin
          foreach (q[i]) if (q[i].tag == int'(bus.cdb_tag[p*TAG_W +: TAG_W])) begin
            q[i].result = bus.cdb_result[p*DATA_W +: DATA_W];
            q[i].target = bus.cdb_target[p*DATA_W +: DATA_W];
            q[i].misp   = bus.cdb_mispredict[p];
            q[i].ready  = 1'b1;
          end
        end
      end
      for (int s = 0; s < n; s++) void'(q.pop_front());
      if (fl) begin
        q.delete();
        tailTag = (lastTag + 1) % DEPTH;
      end
      if (bus.alloc_valid && !bus.freeze && !fl && sz < DEPTH) begin
        e.tag = tailTag; e.dest = bus.alloc_dest; e.info = bus.alloc_info;
        e.result = '0; e.target = '0; e.ready = 1'b0; e.misp = 1'b0;
        q.push_back(e);
        tailTag = (tailTag + 1) % DEPTH;
      end
    end

    @(posedge clk);
    #1;
    chk("commit_valid", 64'(bus.commit_valid), 64'(expCv));
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("commit_tag%0d", s),    64'(bus.commit_tag[s*TAG_W +: TAG_W]),    64'(expTag[s]));
      chk($sformatf("commit_dest%0d", s),   64'(bus.commit_dest[s*5 +: 5]),           64'(expDest[s]));
      chk($sformatf("commit_result%0d", s), 64'(bus.commit_result[s*DATA_W +: DATA_W]), 64'(expRes[s]));
      chk($sformatf("commit_info%0d", s),   64'(bus.commit_info[s*INFO_W +: INFO_W]), 64'(expInfo[s]));
    end
    chk("redirect_valid", 64'(bus.redirect_valid), 64'(expRv));
    chk("redirect_target", 64'(bus.redirect_target), 64'(expRt));
    chk("count_post", 64'(bus.count), 64'(q.size()));
    @(negedge clk);
  endtask

  task automatic allocOne(input int k);
    setIdle();
    bus.alloc_valid = 1'b1;
    bus.alloc_dest = 5'(k + 1);
    bus.alloc_info = INFO_W'(8'h30 + k);
  endtask

  initial begin
    int t;
    reset = 1'b0;
    setIdle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    modelReset();
    reset = 1'b1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    chk("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);

    // 1: fill to full, ninth request ignored
    for (int i = 0; i < 9; i++) begin
      allocOne(i);
      #1;
      if (i < DEPTH) chk("t1_alloc_tag", 64'(bus.alloc_tag), 64'(i));
      step();
    end
    chk("t1_count_full", 64'(bus.count), 64'd8);
    chk("t1_alloc_ready", 64'(bus.alloc_ready), 64'd0);
    setIdle(); reset = 1'b0; step(); reset = 1'b1;

    // 2: out-of-order completion, dual commit
    allocOne(0); step();
    allocOne(1); step();
    setIdle(); setCdb(0, 1, 32'hAA, 1'b0, '0); step();
    setIdle(); setCdb(0, 0, 32'hBB, 1'b0, '0); step();
    setIdle(); step();
    chk("t2_commit_valid", 64'(bus.commit_valid), 64'b11);
    chk("t2_commit_result", bus.commit_result, {32'hAA, 32'hBB});
    chk("t2_commit_tag", 64'(bus.commit_tag), 64'({3'd1, 3'd0}));
    step();

    // 3: mispredict at head flushes younger entries
    for (int i = 0; i < 4; i++) begin allocOne(i); step(); end
    setIdle(); setCdb(0, 2, 32'h22, 1'b1, 32'h100); step();
    setIdle(); step();
    chk("t3_commit_valid", 64'(bus.commit_valid), 64'b01);
    chk("t3_commit_tag0", 64'(bus.commit_tag[TAG_W-1:0]), 64'd2);
    chk("t3_redirect_valid", 64'(bus.redirect_valid), 64'd1);
    chk("t3_redirect_target", 64'(bus.redirect_target), 64'h100);
    chk("t3_count", 64'(bus.count), 64'd0);
    setIdle(); setCdb(0, 4, 32'h44, 1'b0, '0); step();
    setIdle(); step();
    chk("t3_stale_commit", 64'(bus.commit_valid), 64'd0);
    chk("t3_stale_count", 64'(bus.count), 64'd0);
    chk("t3_redirect_pulse", 64'(bus.redirect_valid), 64'd0);

    // 4: operand bypass from CDB port 1
    allocOne(0); step();
    setIdle(); bus.rd_tag_a = 3'd3; setCdb(1, 3, 32'h55, 1'b0, '0);
    #1;
    chk("t4_rd_value_a", 64'(bus.rd_value_a), 64'h55);
    chk("t4_rd_ready_a", 64'(bus.rd_ready_a), 64'd1);
    step();
    setIdle(); step();
    setIdle(); step();

    // 5: streaming allocation with immediate writeback, wrapping tags
    for (int i = 0; i < 20; i++) begin
      allocOne(i);
      if (q.size() > 0) setCdb(0, q[q.size()-1].tag, DATA_W'(32'h1000 + i), 1'b0, '0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      setIdle();
      if (q.size() > 0) setCdb(1, q[q.size()-1].tag, DATA_W'(32'h2000 + i), 1'b0, '0);
      step();
    end

    // 6: reset with live entries and an active broadcast
    setIdle(); reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin allocOne(i); step(); end
    setIdle(); reset = 1'b0; setCdb(0, q[0].tag, 32'h77, 1'b1, 32'h200); step();
    reset = 1'b1; setIdle();
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_empty", 64'(bus.empty), 64'd1);
    chk("t6_commit_valid", 64'(bus.commit_valid), 64'd0);
    chk("t6_redirect_valid", 64'(bus.redirect_valid), 64'd0);

    // Random traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      setIdle();
      reset = ($urandom_range(0, 99) != 0);
      bus.alloc_valid = ($urandom_range(0, 9) < 7);
      bus.freeze = ($urandom_range(0, 9) == 0);
      bus.alloc_dest = 5'($urandom);
      bus.alloc_info = INFO_W'($urandom);
      for (int p = 0; p < NUM_CDB; p++) begin
        if ($urandom_range(0, 9) < 6) begin
          if (q.size() > 0 && $urandom_range(0, 9) < 8) t = q[$urandom_range(0, q.size() - 1)].tag;
          else t = int'($urandom_range(0, DEPTH - 1));
          setCdb(p, t, DATA_W'($urandom), ($urandom_range(0, 15) == 0), DATA_W'($urandom));
        end
      end
      bus.rd_tag_a = TAG_W'($urandom);
      bus.rd_tag_b = TAG_W'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
